// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, opcode constants, FSM state type and
// immediate-decode helpers for the instruction fetch unit.
//   INS_DAT_W / REG_DAT_W : instruction and register/address widths
//   JAL / BRANCH          : major opcodes that the predictor recognises
//   state_t               : fetch FSM states
//   j_imm / b_imm         : sign-extended J-type and B-type immediates
package ifetch_pkg;

  localparam int INS_DAT_W = 32;
  localparam int REG_DAT_W = 32;

  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // J-immediate from instruction bits [31:12].
  function automatic logic [REG_DAT_W-1:0] j_imm(input logic [31:12] hi);
    return {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
  endfunction

  // B-immediate from instruction bits [31:25] and [11:7].
  function automatic logic [REG_DAT_W-1:0] b_imm(input logic [6:0] hi,
                                                 input logic [4:0] lo);
    return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_bht.sv
// bht: branch history table of 2-bit saturating counters.
//   clk, rst            : clock, synchronous active-high reset (all -> 2'b01)
//   rd_idx, rd_taken    : asynchronous read port, MSB of the addressed counter
//   upd_en, upd_idx,
//   upd_taken           : outcome update, visible to reads from the next cycle
module bht #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int NUM = 1 << IDX_W;

  logic [1:0] cnt [NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) cnt[i] <= 2'b01;
    end else if (upd_en) begin
      if (upd_taken && cnt[upd_idx] != 2'b11)
        cnt[upd_idx] <= cnt[upd_idx] + 2'b01;
      else if (!upd_taken && cnt[upd_idx] != 2'b00)
        cnt[upd_idx] <= cnt[upd_idx] - 2'b01;
    end
  end

  assign rd_taken = cnt[rd_idx][1];

endmodule

// File: rtl/ifetch.sv
// ifetch: single-outstanding instruction fetch with static JAL prediction
// and BHT-based conditional-branch prediction.
//   clk, rst, en        : clock, sync active-high reset, global stall (0 = hold)
//   oMC_En, oMC_Addr    : read request (held until response), byte address
//   iMC_En, iMC_Dat     : one-cycle response pulse and instruction
//   oIS_*               : issue pulse, instruction, predicted-jump, pc, next pc
//   iROB_Flush, iROB_Pc : redirect to the correct pc (beats en and responses)
//   iROB_Bht*           : branch outcome update into the BHT
//   dbg_state           : current FSM state
// Handshake: oMC_En rises with a fixed oMC_Addr and stays high until the
// cycle iMC_En is sampled high; that cycle completes the request. oIS_En is
// high for exactly one cycle per delivered instruction, with no back-pressure.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int BHT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 oMC_En,
  output logic [REG_DAT_W-1:0] oMC_Addr,
  input  logic                 iMC_En,
  input  logic [INS_DAT_W-1:0] iMC_Dat,
  output logic                 oIS_En,
  output logic [INS_DAT_W-1:0] oIS_Ins,
  output logic                 oIS_Bj,
  output logic [REG_DAT_W-1:0] oIS_Pc,
  output logic [REG_DAT_W-1:0] oIS_Pjt,
  input  logic                 iROB_Flush,
  input  logic [REG_DAT_W-1:0] iROB_Pc,
  input  logic                 iROB_BhtEn,
  input  logic [REG_DAT_W-1:0] iROB_BhtPc,
  input  logic                 iROB_BhtTaken,
  output state_t               dbg_state
);

  state_t               state;
  logic [REG_DAT_W-1:0] pc;
  logic [INS_DAT_W-1:0] hold_ins;
  logic                 hold_bj;
  logic [REG_DAT_W-1:0] hold_pjt;

  logic                 bht_taken;
  logic                 pred_bj;
  logic [REG_DAT_W-1:0] pred_pjt;
  logic                 unused_bht_pc;

  assign unused_bht_pc = ^{iROB_BhtPc[REG_DAT_W-1:BHT_IDX_W+2], iROB_BhtPc[1:0]};

  bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pc[BHT_IDX_W+1:2]),
    .rd_taken  (bht_taken),
    .upd_en    (iROB_BhtEn),
    .upd_idx   (iROB_BhtPc[BHT_IDX_W+1:2]),
    .upd_taken (iROB_BhtTaken)
  );

  // Prediction for the instruction currently on iMC_Dat, fetched from pc.
  always_comb begin
    pred_bj  = 1'b0;
    pred_pjt = pc + 32'd4;
    case (iMC_Dat[6:0])
      JAL: begin
        pred_bj  = 1'b1;
        pred_pjt = pc + j_imm(iMC_Dat[31:12]);
      end
      BRANCH: begin
        pred_bj = bht_taken;
        if (bht_taken) pred_pjt = pc + b_imm(iMC_Dat[31:25], iMC_Dat[11:7]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      oMC_En   <= 1'b0;
      oMC_Addr <= '0;
      oIS_En   <= 1'b0;
      oIS_Ins  <= '0;
      oIS_Bj   <= 1'b0;
      oIS_Pc   <= '0;
      oIS_Pjt  <= '0;
      hold_ins <= '0;
      hold_bj  <= 1'b0;
      hold_pjt <= '0;
    end else if (iROB_Flush) begin
      pc     <= iROB_Pc;
      oIS_En <= 1'b0;
      // An outstanding request must still be drained; its data is dropped.
      if ((state == WAIT || state == DISCARD) && !iMC_En) begin
        state <= DISCARD;
      end else begin
        state  <= IDLE;
        oMC_En <= 1'b0;
      end
    end else begin
      oIS_En <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            oMC_En   <= 1'b1;
            oMC_Addr <= pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (iMC_En) begin
            oMC_En <= 1'b0;
            if (en) begin
              oIS_En  <= 1'b1;
              oIS_Ins <= iMC_Dat;
              oIS_Bj  <= pred_bj;
              oIS_Pc  <= pc;
              oIS_Pjt <= pred_pjt;
              pc      <= pred_pjt;
              state   <= IDLE;
            end else begin
              hold_ins <= iMC_Dat;
              hold_bj  <= pred_bj;
              hold_pjt <= pred_pjt;
              state    <= HOLD;
            end
          end
        end
        DISCARD: begin
          if (iMC_En) begin
            oMC_En <= 1'b0;
            state  <= IDLE;
          end
        end
        HOLD: begin
          if (en) begin
            oIS_En  <= 1'b1;
            oIS_Ins <= hold_ins;
            oIS_Bj  <= hold_bj;
            oIS_Pc  <= pc;
            oIS_Pjt <= hold_pjt;
            pc      <= hold_pjt;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
